face_detect_mac_pipe: RTL
=========================

Name: face_detect_mac_pipe

Overview:
Parametrised, pipelined multiply / multiply-accumulate unit for the face-detection HLS accelerator. It is the generalised successor of the fixed-width 4-stage multiplier cores: configurable operand widths, signedness, pipeline depth and output width. It carries a valid pipeline and an optional running accumulation mode for integral-image and feature-sum datapaths. It maps to one DSP48 per instance at default widths.

Parameters:
A_WIDTH, 16, width of operand din0
B_WIDTH, 9, width of operand din1
P_WIDTH, 32, output/accumulator width; must be >= A_WIDTH+B_WIDTH (elaboration error otherwise)
NUM_STAGE, 4, total latency in cycles; legal range 2..8 (elaboration error outside)
SIGNED, 0, 0 = unsigned operands, 1 = two's-complement operands

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
ce  in  1  clock enable; 0 freezes the whole pipeline, including the valid bits
in_valid  in  1  din0/din1/acc_* qualify this cycle
din0  in  A_WIDTH  operand A
din1  in  B_WIDTH  operand B
acc_en  in  1  1 = accumulate this product; 0 = plain multiply
acc_clr  in  1  with acc_en=1: start a new sum (load product instead of adding)
dout  out  P_WIDTH  result (product or running sum)
out_valid  out  1  dout valid; high for exactly one ce-cycle per accepted input
ovf  out  1  sticky accumulator-overflow flag

Behaviour:
- Reset (reset=1 at posedge, regardless of ce): all valid bits, dout, ovf and the accumulator go to 0. Operand/product data registers need not reset. In-flight items are discarded; none emerge after reset deasserts.
- An input is accepted on a posedge with ce=1 and in_valid=1. With ce=1 continuously, out_valid rises exactly NUM_STAGE cycles later.
- Stage 1 registers din0, din1, in_valid, acc_en and acc_clr. Stages 2..NUM_STAGE-1 form the product pipeline; the product is full width A_WIDTH+B_WIDTH. The final stage is the accumulator/output register.
- NUM_STAGE=2: the product is formed combinationally between the stage-1 registers and the final register.
- Product extension to P_WIDTH: zero-extend if SIGNED=0, sign-extend if SIGNED=1.
- Final stage, when valid and ce=1:
  - acc_en=0: acc <= prod, ovf <= 0.
  - acc_en=1 and acc_clr=1: acc <= prod, ovf <= 0.
  - acc_en=1 and acc_clr=0: acc <= acc + prod; ovf <= ovf | overflow.
- Overflow detection: unsigned carry-out of P_WIDTH bits (SIGNED=0); signed overflow, i.e. operands of equal sign and result of differing sign (SIGNED=1).
- dout = acc. dout holds its value when out_valid=0. acc_clr with acc_en=0 is ignored.
- ce=0: every register holds, including out_valid. A held out_valid=1 does not count as a second result; the consumer samples only on ce=1 cycles.
- Bubbles (in_valid=0) pass through without disturbing acc.
- Back-to-back accumulation at full throughput (one input per cycle) is required; there is no hazard stall.

Optional Feature:
FACE_DETECT_MAC_SAT_EN
- Defined: on accumulate overflow, acc saturates instead of wrapping. Unsigned clamps to 2^P_WIDTH-1. Signed clamps to 2^(P_WIDTH-1)-1 on positive overflow and -2^(P_WIDTH-1) on negative overflow. ovf is still set.
- Undefined: acc wraps modulo 2^P_WIDTH and ovf is set.
- Plain-multiply results are unaffected in both cases, because P_WIDTH >= A_WIDTH+B_WIDTH.

Test Plan:
1. Defaults, acc_en=0, din0=65535, din1=511 at cycle 0 -> out_valid=1 at cycle 4 only, dout=33488385 (0x1FEFE01), ovf=0.
2. Back-to-back accumulation, all with acc_en=1: (100,3) with acc_clr=1, then (200,2), then (50,4) on consecutive cycles -> dout 300, 700, 900 on cycles 4, 5, 6.
3. ce stall: accept one input, drop ce for 3 cycles while it is mid-pipe -> out_valid appears at cycle 7 with the correct product. out_valid and dout stay frozen while ce=0.
4. SIGNED=1, din0=0xFFFE (-2), din1=3 -> dout=0xFFFFFFFA (-6). Accumulate din0=0x8000, din1=0x0FF on 2 items -> dout=-16711680.
5. P_WIDTH=25, unsigned, accumulate 65535*511 twice (acc_clr on first) -> second dout=33422338 with ovf=1. Under FACE_DETECT_MAC_SAT_EN, second dout=33554431 with ovf=1. A following acc_clr item clears ovf to 0.
6. reset=1 for one cycle while 3 items are in flight -> out_valid=0, dout=0 and ovf=0 the next cycle. No result emerges for the flushed items. A new input is accepted normally NUM_STAGE cycles later.

Source files
------------

// File: rtl/face_detect_mac_pipe.sv
// face_detect_mac_pipe: parametrised pipelined multiply / multiply-accumulate.
// Stage 1 registers the operands, stages 2..NUM_STAGE-1 carry the full-width
// product and the last stage is the accumulator/output register.
// Optional build macro: FACE_DETECT_MAC_SAT_EN (saturate instead of wrap on
// accumulate overflow).
module face_detect_mac_pipe #(
    parameter int A_WIDTH   = 16,
    parameter int B_WIDTH   = 9,
    parameter int P_WIDTH   = 32,
    parameter int NUM_STAGE = 4,
    parameter int SIGNED    = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ce,
    input  logic               in_valid,
    input  logic [A_WIDTH-1:0] din0,
    input  logic [B_WIDTH-1:0] din1,
    input  logic               acc_en,
    input  logic               acc_clr,
    output logic [P_WIDTH-1:0] dout,
    output logic               out_valid,
    output logic               ovf
);
    localparam int AB_WIDTH   = A_WIDTH + B_WIDTH;
    localparam int MID_STAGES = NUM_STAGE - 2;

    generate
        if (P_WIDTH < AB_WIDTH) begin : g_chk_pw
            $error("face_detect_mac_pipe: P_WIDTH must be >= A_WIDTH+B_WIDTH");
        end
        if (NUM_STAGE < 2 || NUM_STAGE > 8) begin : g_chk_ns
            $error("face_detect_mac_pipe: NUM_STAGE must be in 2..8");
        end
    endgenerate

    // Stage 1: operand and control capture
    logic [A_WIDTH-1:0] a_q;
    logic [B_WIDTH-1:0] b_q;
    logic               vld1_q;
    logic               en1_q;
    logic               clr1_q;

    // Stage 1 valid bit: reset clears it so in-flight items are dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            vld1_q <= 1'b0;
        end else if (ce) begin
            vld1_q <= in_valid;
        end
    end

    // Stage 1 data: no reset needed, qualified by the valid bit
    always_ff @(posedge clk) begin
        if (ce) begin
            a_q    <= din0;
            b_q    <= din1;
            en1_q  <= acc_en;
            clr1_q <= acc_clr;
        end
    end

    // Full-width product. Both operands are extended to AB_WIDTH first, so the
    // low AB_WIDTH bits of the unsigned multiply equal the signed product too.
    logic                a_ext;
    logic                b_ext;
    logic [AB_WIDTH-1:0] prod_s1;
    assign a_ext   = (SIGNED != 0) ? a_q[A_WIDTH-1] : 1'b0;
    assign b_ext   = (SIGNED != 0) ? b_q[B_WIDTH-1] : 1'b0;
    assign prod_s1 = {{B_WIDTH{a_ext}}, a_q} * {{A_WIDTH{b_ext}}, b_q};

    // Signals entering the final stage
    logic [AB_WIDTH-1:0] fin_prod;
    logic                fin_vld;
    logic                fin_en;
    logic                fin_clr;

    generate
        if (MID_STAGES == 0) begin : g_direct
            assign fin_prod = prod_s1;
            assign fin_vld  = vld1_q;
            assign fin_en   = en1_q;
            assign fin_clr  = clr1_q;
        end else begin : g_pipe
            genvar gi;
            for (gi = 0; gi < MID_STAGES; gi++) begin : g_stage
                logic [AB_WIDTH-1:0] prod_q;
                logic                vld_q;
                logic                en_q;
                logic                clr_q;
                logic [AB_WIDTH-1:0] prod_d;
                logic                vld_d;
                logic                en_d;
                logic                clr_d;
                if (gi == 0) begin : g_first
                    assign prod_d = prod_s1;
                    assign vld_d  = vld1_q;
                    assign en_d   = en1_q;
                    assign clr_d  = clr1_q;
                end else begin : g_next
                    assign prod_d = g_stage[gi-1].prod_q;
                    assign vld_d  = g_stage[gi-1].vld_q;
                    assign en_d   = g_stage[gi-1].en_q;
                    assign clr_d  = g_stage[gi-1].clr_q;
                end
                // Product pipeline stage: valid resets, data just shifts on ce
                always_ff @(posedge clk) begin
                    if (reset) begin
                        vld_q <= 1'b0;
                    end else if (ce) begin
                        vld_q <= vld_d;
                    end
                    if (ce) begin
                        prod_q <= prod_d;
                        en_q   <= en_d;
                        clr_q  <= clr_d;
                    end
                end
            end
            assign fin_prod = g_stage[MID_STAGES-1].prod_q;
            assign fin_vld  = g_stage[MID_STAGES-1].vld_q;
            assign fin_en   = g_stage[MID_STAGES-1].en_q;
            assign fin_clr  = g_stage[MID_STAGES-1].clr_q;
        end
    endgenerate

    // Product extended to the accumulator width
    logic [P_WIDTH-1:0] prod_ext;
    generate
        if (SIGNED != 0) begin : g_sext
            assign prod_ext = P_WIDTH'($signed(fin_prod));
        end else begin : g_zext
            assign prod_ext = P_WIDTH'(fin_prod);
        end
    endgenerate

    // Final stage state
    logic [P_WIDTH-1:0] acc_q;
    logic [P_WIDTH-1:0] acc_d;
    logic               ovf_q;
    logic               ovf_d;
    logic               vout_q;
    logic               vout_d;

    // Adder with carry-out; overflow test depends on operand signedness
    logic [P_WIDTH:0]   sum_full;
    logic [P_WIDTH-1:0] sum;
    logic               add_ovf;
    logic [P_WIDTH-1:0] acc_sum;
    assign sum_full = {1'b0, acc_q} + {1'b0, prod_ext};
    assign sum      = sum_full[P_WIDTH-1:0];
    assign add_ovf  = (SIGNED != 0)
                    ? ((acc_q[P_WIDTH-1] == prod_ext[P_WIDTH-1]) && (sum[P_WIDTH-1] != acc_q[P_WIDTH-1]))
                    : sum_full[P_WIDTH];

`ifdef FACE_DETECT_MAC_SAT_EN
    // Clamp value: both operands share a sign on signed overflow, so acc's
    // sign tells the overflow direction
    logic [P_WIDTH-1:0] sat_val;
    assign sat_val = (SIGNED == 0)       ? {P_WIDTH{1'b1}} :
                     acc_q[P_WIDTH-1]    ? {1'b1, {(P_WIDTH-1){1'b0}}} :
                                           {1'b0, {(P_WIDTH-1){1'b1}}};
    assign acc_sum = add_ovf ? sat_val : sum;
`else
    assign acc_sum = sum;
`endif

    // Final-stage next state: load product, or add it to the running sum
    always_comb begin
        acc_d  = acc_q;
        ovf_d  = ovf_q;
        vout_d = fin_vld;
        if (fin_vld) begin
            if (fin_en && !fin_clr) begin
                acc_d = acc_sum;
                ovf_d = ovf_q | add_ovf;
            end else begin
                acc_d = prod_ext;
                ovf_d = 1'b0;
            end
        end
    end

    // Final-stage register: accumulator, sticky overflow and output valid
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q  <= '0;
            ovf_q  <= 1'b0;
            vout_q <= 1'b0;
        end else if (ce) begin
            acc_q  <= acc_d;
            ovf_q  <= ovf_d;
            vout_q <= vout_d;
        end
    end

    assign dout      = acc_q;
    assign ovf       = ovf_q;
    assign out_valid = vout_q;
endmodule
